// File: rtl/hot_page_push_pkg.sv
// Shared types and constants for the hot-page push path.
// Covers the address-pair record and the migration dispatcher FSM states.
package hot_page_push_pkg;

   localparam int PAGE_SHIFT = 12;

   typedef struct packed {
      logic [63:0] src;
      logic [63:0] dst;
   } mig_pair_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DISPATCH,
      DONE
   } mig_disp_state_e;

endpackage

// File: rtl/hot_page_mig_chan.sv
// One copy-engine channel: group snapshot, dispatch pointer with zero-source skip,
// registered valid/ready request and a credit-limited outstanding-copy counter.
module hot_page_mig_chan
   import hot_page_push_pkg::*;
#(
   parameter int NP      = 8,
   parameter int MAX_OUT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 capture,
   input  logic                 enable,
   input  logic [NP-1:0][63:0]  src_addr,
   input  logic [NP-1:0][63:0]  dst_addr,
   output logic                 req_valid,
   output logic [63:0]          req_src,
   output logic [63:0]          req_dst,
   input  logic                 req_ready,
   input  logic                 done,
   output logic                 finished,
   output logic                 err_underflow
);

   localparam int PW = $clog2(NP + 1);
   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int IW = (NP > 1) ? $clog2(NP) : 1;
   localparam logic [PW-1:0] PTR_END = PW'(NP);
   localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUT);

   mig_pair_t       snap [NP];
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   ptr_next;
   logic [PW-1:0]   cand;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   out_next;
   logic            accept;
   logic            dec;
   logic            under;
   logic            cand_ok;
   logic            cand_zero;
   logic            hold;
   logic            issue;
   mig_pair_t       cand_pair;

   function automatic logic [IW-1:0] to_idx(input logic [PW-1:0] p);
      return IW'(p);
   endfunction

   // The candidate is the pair the request register would load at this edge:
   // the one after the accepted request, or the current pointer when idle.
   always_comb begin
      accept    = req_valid & req_ready;
      dec       = done & ((outstanding != '0) | accept);
      under     = done & (outstanding == '0) & ~accept;
      out_next  = outstanding + OW'(accept) - OW'(dec);
      cand      = accept ? ptr + PW'(1) : ptr;
      cand_ok   = cand < PTR_END;
      cand_pair = cand_ok ? snap[to_idx(cand)] : '0;
      cand_zero = (cand_pair.src == '0);
      hold      = req_valid & ~req_ready;
      issue     = enable & cand_ok & ~cand_zero & (out_next < OUT_MAX) &
                  (~req_valid | accept);
      ptr_next  = ptr;
      if (enable) begin
         if (accept) begin
            ptr_next = cand;
         end else if (~req_valid && cand_ok && cand_zero) begin
            ptr_next = ptr + PW'(1);
         end
      end
      finished = (ptr == PTR_END) && (outstanding == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NP; i++) begin
            snap[i] <= '0;
         end
         ptr           <= '0;
         outstanding   <= '0;
         err_underflow <= 1'b0;
         req_valid     <= 1'b0;
         req_src       <= '0;
         req_dst       <= '0;
      end else begin
         if (capture) begin
            for (int i = 0; i < NP; i++) begin
               snap[i] <= '{src: src_addr[i], dst: dst_addr[i]};
            end
            ptr <= '0;
         end else begin
            ptr <= ptr_next;
         end
         outstanding <= out_next;
         if (under) begin
            err_underflow <= 1'b1;
         end
         // A raised request is frozen until the engine takes it, even if credit runs out.
         if (!enable) begin
            req_valid <= 1'b0;
            req_src   <= '0;
            req_dst   <= '0;
         end else if (hold) begin
            req_valid <= 1'b1;
         end else if (issue) begin
            req_valid <= 1'b1;
            req_src   <= cand_pair.src;
            req_dst   <= cand_pair.dst;
         end else begin
            req_valid <= 1'b0;
            req_src   <= '0;
            req_dst   <= '0;
         end
      end
   end

endmodule

// File: rtl/hot_page_mig_dispatcher.sv
// Page-migration dispatcher: snapshots a group of address pairs, feeds them to two
// copy-engine channels and counts completed and dropped groups.
module hot_page_mig_dispatcher
   import hot_page_push_pkg::*;
#(
   parameter  int MIG_GRP_SIZE = 16,
   parameter  int MAX_OUT      = 4,
   localparam int NP           = MIG_GRP_SIZE / 2
) (
   input  logic                 axi4_mm_clk,
   input  logic                 axi4_mm_rst,
   input  logic                 new_addr_available,
   input  logic [NP-1:0][63:0]  src_addr,
   input  logic [NP-1:0][63:0]  dst_addr,
   input  logic [NP-1:0][63:0]  src_addr1,
   input  logic [NP-1:0][63:0]  dst_addr1,
   output logic [1:0]           cp_req_valid,
   output logic [1:0][63:0]     cp_req_src,
   output logic [1:0][63:0]     cp_req_dst,
   input  logic [1:0]           cp_req_ready,
   input  logic [1:0]           cp_done,
   output logic                 busy,
   output logic [63:0]          mig_done_cnt,
   output logic [31:0]          grp_drop_cnt,
   output logic                 err_done_underflow
);

   mig_disp_state_e state;
   mig_disp_state_e state_next;
   logic            capture;
   logic            enable;
   logic [1:0]      finished;
   logic [1:0]      err;

   assign capture            = new_addr_available && (state == IDLE);
   assign enable             = (state == LOAD) || (state == DISPATCH);
   assign busy               = (state != IDLE);
   assign err_done_underflow = |err;

   hot_page_mig_chan #(.NP(NP), .MAX_OUT(MAX_OUT)) u_chan0 (
      .clk           (axi4_mm_clk),
      .rst           (axi4_mm_rst),
      .capture       (capture),
      .enable        (enable),
      .src_addr      (src_addr),
      .dst_addr      (dst_addr),
      .req_valid     (cp_req_valid[0]),
      .req_src       (cp_req_src[0]),
      .req_dst       (cp_req_dst[0]),
      .req_ready     (cp_req_ready[0]),
      .done          (cp_done[0]),
      .finished      (finished[0]),
      .err_underflow (err[0])
   );

   hot_page_mig_chan #(.NP(NP), .MAX_OUT(MAX_OUT)) u_chan1 (
      .clk           (axi4_mm_clk),
      .rst           (axi4_mm_rst),
      .capture       (capture),
      .enable        (enable),
      .src_addr      (src_addr1),
      .dst_addr      (dst_addr1),
      .req_valid     (cp_req_valid[1]),
      .req_src       (cp_req_src[1]),
      .req_dst       (cp_req_dst[1]),
      .req_ready     (cp_req_ready[1]),
      .done          (cp_done[1]),
      .finished      (finished[1]),
      .err_underflow (err[1])
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (new_addr_available) state_next = LOAD;
         LOAD:     state_next = DISPATCH;
         DISPATCH: if (&finished) state_next = DONE;
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // A pulse outside IDLE is a dropped group; the drop counter saturates.
   always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
      if (axi4_mm_rst) begin
         state        <= IDLE;
         mig_done_cnt <= '0;
         grp_drop_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == DONE) begin
            mig_done_cnt <= mig_done_cnt + 64'd1;
         end
         if (new_addr_available && (state != IDLE) && (grp_drop_cnt != '1)) begin
            grp_drop_cnt <= grp_drop_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_hot_page_mig_dispatcher.sv
// Directed bench for hot_page_mig_dispatcher with a small copy-engine model
// that can complete copies after a delay, drain them, or leave them to the test.
module tb_hot_page_mig_dispatcher;

   localparam int NP = 8;

   logic                clk;
   logic                rst;
   logic                new_addr_available;
   logic [NP-1:0][63:0] src_addr;
   logic [NP-1:0][63:0] dst_addr;
   logic [NP-1:0][63:0] src_addr1;
   logic [NP-1:0][63:0] dst_addr1;
   logic [1:0]          cp_req_valid;
   logic [1:0][63:0]    cp_req_src;
   logic [1:0][63:0]    cp_req_dst;
   logic [1:0]          cp_req_ready;
   logic [1:0]          cp_done;
   logic                busy;
   logic [63:0]         mig_done_cnt;
   logic [31:0]         grp_drop_cnt;
   logic                err_done_underflow;

   int          total;
   int          bad;
   int          cyc;
   int          done_mode;
   int          done_delay;
   int          acc_n [2];
   int          model_out [2];
   int          acc_cyc0 [$];
   logic [63:0] seq0 [$];
   logic [63:0] seq1 [$];
   int          due0 [$];
   int          due1 [$];
   int          last_done_edge;
   int          idle_cyc;

   hot_page_mig_dispatcher #(.MIG_GRP_SIZE(16), .MAX_OUT(4)) dut (
      .axi4_mm_clk        (clk),
      .axi4_mm_rst        (rst),
      .new_addr_available (new_addr_available),
      .src_addr           (src_addr),
      .dst_addr           (dst_addr),
      .src_addr1          (src_addr1),
      .dst_addr1          (dst_addr1),
      .cp_req_valid       (cp_req_valid),
      .cp_req_src         (cp_req_src),
      .cp_req_dst         (cp_req_dst),
      .cp_req_ready       (cp_req_ready),
      .cp_done            (cp_done),
      .busy               (busy),
      .mig_done_cnt       (mig_done_cnt),
      .grp_drop_cnt       (grp_drop_cnt),
      .err_done_underflow (err_done_underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // One clock: log handshakes seen before the edge, then drive cp_done for the next cycle.
   task automatic step();
      logic [1:0] acc;
      logic [1:0] dn;
      acc = cp_req_valid & cp_req_ready;
      dn  = cp_done;
      if (acc[0]) begin
         seq0.push_back(cp_req_src[0]);
         acc_cyc0.push_back(cyc + 1);
         acc_n[0]++;
      end
      if (acc[1]) begin
         seq1.push_back(cp_req_src[1]);
         acc_n[1]++;
      end
      for (int c = 0; c < 2; c++) begin
         model_out[c] = model_out[c] + int'(acc[c]) - int'(dn[c] && (model_out[c] > 0 || acc[c]));
      end
      @(posedge clk);
      #1;
      cyc++;
      if (done_mode == 1) begin
         if (acc[0]) due0.push_back(cyc + done_delay);
         if (acc[1]) due1.push_back(cyc + done_delay);
      end
      cp_done = 2'b00;
      if (done_mode == 1) begin
         if (due0.size() > 0 && due0[0] <= cyc) begin
            cp_done[0] = 1'b1;
            void'(due0.pop_front());
         end
         if (due1.size() > 0 && due1[0] <= cyc) begin
            cp_done[1] = 1'b1;
            void'(due1.pop_front());
         end
      end else if (done_mode == 2) begin
         cp_done[0] = (model_out[0] > 0);
         cp_done[1] = (model_out[1] > 0);
      end
      if (cp_done != 2'b00) last_done_edge = cyc + 1;
   endtask

   task automatic clear_log();
      acc_n[0] = 0;
      acc_n[1] = 0;
      seq0.delete();
      seq1.delete();
      acc_cyc0.delete();
   endtask

   // Pattern 0: nominal addresses; 1: ch0 index 3 and all of ch1 zero; 2: alternate group.
   task automatic applyStimulus(input int pattern);
      for (int i = 0; i < NP; i++) begin
         src_addr[i]  = 64'h1000 * 64'(i + 1);
         dst_addr[i]  = 64'h80000 + 64'h1000 * 64'(i);
         src_addr1[i] = 64'h100000 + 64'h1000 * 64'(i);
         dst_addr1[i] = 64'h200000 + 64'h1000 * 64'(i);
         if (pattern == 1) src_addr1[i] = '0;
         if (pattern == 2) begin
            src_addr[i]  = 64'hdead000;
            src_addr1[i] = 64'hbeef000;
         end
      end
      if (pattern == 1) src_addr[3] = '0;
      new_addr_available = 1'b1;
      step();
      new_addr_available = 1'b0;
   endtask

   task automatic run_until_idle(input string tag, input int limit);
      int n;
      n = 0;
      while (busy && n < limit) begin
         step();
         n++;
      end
      idle_cyc = cyc;
      checkOutput(tag, 64'(busy), 64'd0);
   endtask

   initial begin
      total = 0;
      bad = 0;
      cyc = 0;
      done_mode = 0;
      done_delay = 5;
      model_out[0] = 0;
      model_out[1] = 0;
      last_done_edge = 0;
      idle_cyc = 0;
      clear_log();
      rst = 1'b1;
      new_addr_available = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      src_addr1 = '0;
      dst_addr1 = '0;
      cp_req_ready = 2'b11;
      cp_done = 2'b00;

      step();
      step();
      checkOutput("rst_valid", 64'(cp_req_valid), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done_cnt", mig_done_cnt, 64'd0);
      checkOutput("rst_drop_cnt", 64'(grp_drop_cnt), 64'd0);
      checkOutput("rst_err", 64'(err_done_underflow), 64'd0);
      rst = 1'b0;
      step();

      $display("[TB] nominal group");
      done_mode = 1;
      done_delay = 5;
      applyStimulus(0);
      checkOutput("nom_load_valid", 64'(cp_req_valid), 64'd0);
      checkOutput("nom_load_busy", 64'(busy), 64'd1);
      step();
      checkOutput("nom_first_valid", 64'(cp_req_valid), 64'd3);
      checkOutput("nom_first_src0", cp_req_src[0], 64'h1000);
      checkOutput("nom_first_dst0", cp_req_dst[0], 64'h80000);
      checkOutput("nom_first_src1", cp_req_src[1], 64'h100000);
      checkOutput("nom_cnt_before", mig_done_cnt, 64'd0);
      run_until_idle("nom_idle", 300);
      checkOutput("nom_acc0", 64'(acc_n[0]), 64'd8);
      checkOutput("nom_acc1", 64'(acc_n[1]), 64'd8);
      checkOutput("nom_b2b", 64'(acc_cyc0[3] - acc_cyc0[0]), 64'd3);
      for (int k = 0; k < NP; k++) begin
         checkOutput("nom_seq0", seq0[k], 64'h1000 * 64'(k + 1));
      end
      checkOutput("nom_seq1_last", seq1[7], 64'h107000);
      checkOutput("nom_cnt_after", mig_done_cnt, 64'd1);
      checkOutput("nom_busy_fall", 64'(idle_cyc - last_done_edge), 64'd2);

      $display("[TB] backpressure on channel 0");
      clear_log();
      done_delay = 1;
      cp_req_ready = 2'b10;
      applyStimulus(0);
      step();
      checkOutput("bp_first_valid0", 64'(cp_req_valid[0]), 64'd1);
      for (int k = 0; k < 10; k++) begin
         step();
         checkOutput("bp_hold_valid0", 64'(cp_req_valid[0]), 64'd1);
         checkOutput("bp_hold_src0", cp_req_src[0], 64'h1000);
      end
      checkOutput("bp_acc0_stalled", 64'(acc_n[0]), 64'd0);
      checkOutput("bp_acc1_all", 64'(acc_n[1]), 64'd8);
      cp_req_ready = 2'b11;
      run_until_idle("bp_idle", 300);
      checkOutput("bp_acc0", 64'(acc_n[0]), 64'd8);
      checkOutput("bp_seq0_first", seq0[0], 64'h1000);
      checkOutput("bp_cnt", mig_done_cnt, 64'd2);

      $display("[TB] zero-source skips");
      clear_log();
      done_delay = 5;
      applyStimulus(1);
      run_until_idle("skip_idle", 300);
      checkOutput("skip_acc0", 64'(acc_n[0]), 64'd7);
      checkOutput("skip_acc1", 64'(acc_n[1]), 64'd0);
      checkOutput("skip_seq0_2", seq0[2], 64'h3000);
      checkOutput("skip_seq0_3", seq0[3], 64'h5000);
      checkOutput("skip_cnt", mig_done_cnt, 64'd3);

      $display("[TB] credit limit");
      clear_log();
      done_mode = 0;
      applyStimulus(0);
      for (int k = 0; k < 8; k++) step();
      checkOutput("cred_acc0", 64'(acc_n[0]), 64'd4);
      checkOutput("cred_valid0_off", 64'(cp_req_valid[0]), 64'd0);
      cp_done = 2'b01;
      step();
      checkOutput("cred_refill_valid0", 64'(cp_req_valid[0]), 64'd1);
      checkOutput("cred_refill_src0", cp_req_src[0], 64'h5000);
      cp_done = 2'b01;
      step();
      checkOutput("cred_same_cyc_valid0", 64'(cp_req_valid[0]), 64'd1);
      checkOutput("cred_same_cyc_src0", cp_req_src[0], 64'h6000);
      step();
      checkOutput("cred_acc0_6", 64'(acc_n[0]), 64'd6);
      checkOutput("cred_valid0_full", 64'(cp_req_valid[0]), 64'd0);
      done_mode = 2;
      run_until_idle("cred_idle", 300);
      checkOutput("cred_acc0_all", 64'(acc_n[0]), 64'd8);
      checkOutput("cred_cnt", mig_done_cnt, 64'd4);
      checkOutput("cred_err", 64'(err_done_underflow), 64'd0);

      $display("[TB] group drop and underflow");
      clear_log();
      done_mode = 1;
      applyStimulus(0);
      step();
      step();
      step();
      applyStimulus(2);
      checkOutput("drop_cnt_now", 64'(grp_drop_cnt), 64'd1);
      run_until_idle("drop_idle", 300);
      checkOutput("drop_acc0", 64'(acc_n[0]), 64'd8);
      checkOutput("drop_seq0_0", seq0[0], 64'h1000);
      checkOutput("drop_seq0_7", seq0[7], 64'h8000);
      checkOutput("drop_seq1_7", seq1[7], 64'h107000);
      checkOutput("drop_cnt", mig_done_cnt, 64'd5);
      checkOutput("drop_err_before", 64'(err_done_underflow), 64'd0);
      done_mode = 0;
      cp_done = 2'b10;
      step();
      step();
      checkOutput("under_err", 64'(err_done_underflow), 64'd1);
      checkOutput("under_busy", 64'(busy), 64'd0);

      $display("[TB] reset mid-dispatch");
      clear_log();
      due0.delete();
      due1.delete();
      done_mode = 1;
      applyStimulus(0);
      for (int k = 0; k < 50 && acc_n[0] < 3; k++) step();
      checkOutput("mid_acc0", 64'(acc_n[0]), 64'd3);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_valid", 64'(cp_req_valid), 64'd0);
      checkOutput("mid_rst_src0", cp_req_src[0], 64'd0);
      checkOutput("mid_rst_busy", 64'(busy), 64'd0);
      checkOutput("mid_rst_cnt", mig_done_cnt, 64'd0);
      checkOutput("mid_rst_drop", 64'(grp_drop_cnt), 64'd0);
      checkOutput("mid_rst_err", 64'(err_done_underflow), 64'd0);
      step();
      step();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) step();
      checkOutput("late_done_err", 64'(err_done_underflow), 64'd1);
      checkOutput("late_done_busy", 64'(busy), 64'd0);
      due0.delete();
      due1.delete();
      model_out[0] = 0;
      model_out[1] = 0;
      cp_done = 2'b00;
      done_mode = 2;
      clear_log();
      applyStimulus(0);
      checkOutput("restart_load_valid", 64'(cp_req_valid), 64'd0);
      step();
      checkOutput("restart_valid0", 64'(cp_req_valid[0]), 64'd1);
      checkOutput("restart_src0", cp_req_src[0], 64'h1000);
      run_until_idle("restart_idle", 300);
      checkOutput("restart_acc0", 64'(acc_n[0]), 64'd8);
      checkOutput("restart_cnt", mig_done_cnt, 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
